// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - Wishbone UART transmitter with transmit FIFO, run-time baud divisor and irq
//
// Purpose: queues bytes written over the bus and serialises them on tx as
// start / DATA_BITS (LSB first) / STOP_BITS frames, with a period of
// max(DIV,1) clocks per bit.
//
// Ports:
//   wb_clk    system clock, rising edge
//   wb_rst_n  asynchronous active-low reset
//   wb_cyc    chip-select, held until wb_ack
//   wb_we     write strobe
//   wb_adr    register index: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL
//   wb_dat    write data
//   wb_rdt    registered read data, 0 outside an acknowledged read
//   wb_ack    one-cycle acknowledge
//   tx        serial output, idle high
//   irq       level interrupt: irq_en and transmitter fully drained
module uart_tx_fifo #(
   parameter int DEPTH       = 16,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 32
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        wb_cyc,
   input  logic        wb_we,
   input  logic [1:0]  wb_adr,
   input  logic [31:0] wb_dat,
   output logic [31:0] wb_rdt,
   output logic        wb_ack,
   output logic        tx,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 r_ovf;
   logic                 r_en;
   logic                 r_irq_en;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_period;
   logic [DIV_WIDTH-1:0] r_baud_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_cnt;
   logic                 r_tx;
   logic                 r_ack;
   logic [31:0]          r_rdt;
   state_t               r_state;

   state_t               w_state_nxt;
   logic                 w_acc;
   logic                 w_wr;
   logic                 w_push;
   logic                 w_push_ok;
   logic                 w_pop;
   logic                 w_flush;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_busy;
   logic                 w_tick;
   logic                 w_tx_nxt;
   logic [DIV_WIDTH-1:0] w_div_eff;
   logic [7:0]           w_count8;
   logic [31:0]          w_rd_data;
   logic                 w_unused_dat;

   // A transaction takes effect only on the edge that raises wb_ack, so a
   // held wb_cyc cannot repeat a side effect.
   assign w_acc     = wb_cyc & ~r_ack;
   assign w_wr      = w_acc & wb_we;
   assign w_push    = w_wr & (wb_adr == 2'd0);
   assign w_flush   = w_wr & (wb_adr == 2'd3) & wb_dat[2];
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   // Full is judged on the current occupancy, so a pop on the same edge
   // does not rescue a push at full.
   assign w_push_ok = w_push & ~w_full;
   assign w_busy    = (r_state != S_IDLE);
   assign w_div_eff = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
   assign w_tick    = (r_baud_cnt == '0);
   assign w_count8  = 8'(r_count);
   assign w_unused_dat = ^wb_dat;

   assign wb_ack = r_ack;
   assign wb_rdt = r_rdt;
   assign tx     = r_tx;
   assign irq    = r_irq_en & w_empty & ~w_busy;

   always_comb begin
      w_rd_data = '0;
      case (wb_adr)
         2'd1:    w_rd_data = {8'h0, w_count8, 12'h0, r_ovf, w_busy, w_full, w_empty};
         2'd2:    w_rd_data[DIV_WIDTH-1:0] = r_div;
         2'd3:    w_rd_data[1:0] = {r_irq_en, r_en};
         default: w_rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_ack    <= 1'b0;
         r_rdt    <= '0;
         r_div    <= DIV_WIDTH'(DEFAULT_DIV);
         r_en     <= 1'b1;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_ack <= w_acc;
         r_rdt <= (w_acc & ~wb_we) ? w_rd_data : '0;
         if (w_wr && wb_adr == 2'd2) begin
            r_div <= wb_dat[DIV_WIDTH-1:0];
         end
         if (w_wr && wb_adr == 2'd3) begin
            r_en     <= wb_dat[0];
            r_irq_en <= wb_dat[1];
         end
         if (w_push && w_full) begin
            r_ovf <= 1'b1;
         end else if (w_wr && wb_adr == 2'd1 && wb_dat[3]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wb_dat[DATA_BITS-1:0];
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         // Flush only realigns the read side; a byte already in the shift
         // register keeps transmitting.
         if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else begin
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // tx is registered from the state, so the line lags the state by one
   // clock uniformly; frame length and contiguity are unaffected.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (r_en && !w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_tick) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_tick && r_bit_cnt == 3'(DATA_BITS - 1)) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_tick && r_bit_cnt == 3'(STOP_BITS - 1)) begin
               if (r_en && !w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The divisor is captured per frame, so DIV writes apply from the next pop.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_tx       <= 1'b1;
         r_period   <= DIV_WIDTH'(1);
         r_baud_cnt <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
      end else begin
         r_tx <= w_tx_nxt;
         if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_period   <= w_div_eff;
            r_baud_cnt <= w_div_eff - DIV_WIDTH'(1);
            r_bit_cnt  <= '0;
         end else if (r_state != S_IDLE) begin
            if (w_tick) begin
               r_baud_cnt <= r_period - DIV_WIDTH'(1);
               if (r_state == S_DATA) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= (r_bit_cnt == 3'(DATA_BITS - 1)) ? 3'd0 : r_bit_cnt + 3'd1;
               end else if (r_state == S_STOP) begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end else begin
               r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

   localparam int DEPTH     = 16;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   logic        wb_clk   = 1'b0;
   logic        wb_rst_n = 1'b0;
   logic        wb_cyc   = 1'b0;
   logic        wb_we    = 1'b0;
   logic [1:0]  wb_adr   = 2'd0;
   logic [31:0] wb_dat   = 32'd0;
   logic [31:0] wb_rdt;
   logic        wb_ack;
   logic        tx;
   logic        irq;

   typedef struct {
      logic [7:0] data;
      int         period;
   } frame_t;

   frame_t sb[$];
   int     start_cyc[$];
   int     n_chk       = 0;
   int     n_pass      = 0;
   int     cyc_n       = 0;
   int     frames      = 0;
   int     last_ack    = 0;
   int     cur_div     = 32;
   bit     mon_ignore  = 1'b0;

   uart_tx_fifo #(
      .DEPTH(DEPTH), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
      .DIV_WIDTH(16), .DEFAULT_DIV(32)
   ) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_cyc(wb_cyc), .wb_we(wb_we),
      .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_rdt(wb_rdt), .wb_ack(wb_ack),
      .tx(tx), .irq(irq)
   );

   always #5 wb_clk = ~wb_clk;
   always @(posedge wb_clk) cyc_n <= cyc_n + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                          output logic [31:0] rdt);
      int n;
      @(negedge wb_clk);
      wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
      n = 0;
      do begin
         @(negedge wb_clk);
         n++;
      end while (!wb_ack && n < 8);
      check_eq("ack", wb_ack, 1);
      rdt      = wb_rdt;
      last_ack = cyc_n;
      wb_cyc = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_wr(input logic [1:0] adr, input logic [31:0] dat);
      logic [31:0] d;
      wb_xfer(1'b1, adr, dat, d);
   endtask

   task automatic wb_rd(input logic [1:0] adr, output logic [31:0] rdt);
      wb_xfer(1'b0, adr, 32'd0, rdt);
   endtask

   task automatic set_div(input int d);
      wb_wr(2'd2, d);
      cur_div = d & 16'hFFFF;
   endtask

   task automatic send(input logic [7:0] d, input bit expect_tx);
      frame_t f;
      wb_wr(2'd0, {24'd0, d});
      if (expect_tx) begin
         f.data   = d;
         f.period = (cur_div == 0) ? 1 : cur_div;
         sb.push_back(f);
      end
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frames < target && n < 400) begin
         @(negedge wb_clk);
         n++;
      end
      check_eq("frame_wait", frames >= target, 1);
   endtask

   task automatic wait_done(input bit need_empty);
      logic [31:0] s;
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 300) begin
         wb_rd(2'd1, s);
         done = !s[2] && (s[0] || !need_empty);
         n++;
      end
      check_eq("idle_wait", done, 1);
   endtask

   // Line monitor: every clock of a frame is compared against the ideal
   // waveform built from the scoreboard entry popped at the start bit.
   initial begin
      frame_t     f;
      int         errs;
      int         total;
      int         bi;
      logic       e;
      logic [7:0] got;
      forever begin
         @(negedge wb_clk);
         if (wb_rst_n && tx === 1'b0) begin
            frames++;
            start_cyc.push_back(cyc_n);
            check_eq("rx_expected", sb.size() != 0, 1);
            if (sb.size() != 0) f = sb.pop_front();
            else begin
               f.data = 8'h00;
               f.period = 1;
            end
            errs  = 0;
            got   = 8'h00;
            total = (1 + DATA_BITS + STOP_BITS) * f.period;
            for (int j = 0; j < total; j++) begin
               bi = j / f.period;
               if (bi == 0) e = 1'b0;
               else if (bi <= DATA_BITS) e = f.data[bi-1];
               else e = 1'b1;
               if (tx !== e) errs++;
               if (bi >= 1 && bi <= DATA_BITS && (j % f.period) == f.period / 2) got[bi-1] = tx;
               if (j != total - 1) @(negedge wb_clk);
            end
            if (!mon_ignore) begin
               check_eq("rx_data", got, f.data);
               check_eq("rx_shape_errs", errs, 0);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got time limit reached, expected test completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int fs;
      int pk;
      int n;

      repeat (3) @(negedge wb_clk);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_ack", wb_ack, 0);
      check_eq("rst_rdt", wb_rdt, 0);
      check_eq("rst_irq", irq, 0);
      wb_rst_n = 1'b1;
      wb_rd(2'd1, r); check_eq("rst_status", r, 32'h0000_0001);
      wb_rd(2'd2, r); check_eq("rst_div", r, 32);
      wb_rd(2'd3, r); check_eq("rst_ctrl", r, 32'h1);
      @(negedge wb_clk); check_eq("rdt_idle", wb_rdt, 0);
      wb_rd(2'd0, r); check_eq("data_read", r, 0);
      set_div(32'hFFFF_FFFF);
      wb_rd(2'd2, r); check_eq("div_upper", r, 32'h0000_FFFF);
      wb_wr(2'd3, 32'h7);
      wb_rd(2'd3, r); check_eq("ctrl_flush_rd", r, 32'h3);
      wb_wr(2'd3, 32'h1);

      // basic frame
      set_div(4);
      fs = frames;
      send(8'h55, 1);
      pk = last_ack;
      wait_frames(fs + 1);
      check_eq("start_latency", start_cyc[fs] - pk, 2);
      wait_done(1);
      check_eq("basic_frames", frames - fs, 1);

      // back-to-back
      set_div(2);
      fs = frames;
      send(8'h01, 1); send(8'h80, 1); send(8'hFF, 1);
      wb_rd(2'd1, r); check_eq("b2b_count_a", r[23:16], 2);
      wait_frames(fs + 2);
      wb_rd(2'd1, r); check_eq("b2b_count_b", r[23:16], 1);
      wait_frames(fs + 3);
      wb_rd(2'd1, r); check_eq("b2b_count_c", r[23:16], 0);
      wait_done(1);
      check_eq("b2b_gap1", start_cyc[fs+1] - start_cyc[fs], 20);
      check_eq("b2b_gap2", start_cyc[fs+2] - start_cyc[fs+1], 20);

      // flush during frame 1
      fs = frames;
      send(8'hA1, 1); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 0);
      wb_wr(2'd3, 32'h5);
      wait_done(1);
      check_eq("flush_frames", frames - fs, 1);
      wb_rd(2'd1, r); check_eq("flush_status", r, 32'h0000_0001);

      // disable mid-frame
      fs = frames;
      send(8'hE5, 1); send(8'hF6, 0);
      wb_wr(2'd3, 32'h0);
      wait_done(0);
      check_eq("dis_frames", frames - fs, 1);
      wb_rd(2'd1, r); check_eq("dis_status", r, 32'h0001_0000);
      wb_wr(2'd3, 32'h4);
      wb_rd(2'd1, r); check_eq("dis_flush", r, 32'h0000_0001);

      // overflow, ovf clear, divisor 0 acts as 1
      set_div(0);
      fs = frames;
      for (int i = 0; i < DEPTH; i++) send(8'(i * 17 + 3), 1);
      send(8'hAA, 0);
      wb_rd(2'd1, r); check_eq("ovf_status", r, 32'h0010_000A);
      wb_wr(2'd1, 32'h7);
      wb_rd(2'd1, r); check_eq("ovf_keep", r, 32'h0010_000A);
      wb_wr(2'd1, 32'h8);
      wb_rd(2'd1, r); check_eq("ovf_clear", r, 32'h0010_0002);
      wb_rd(2'd2, r); check_eq("div_zero", r, 0);
      wb_wr(2'd3, 32'h1);
      wait_done(1);
      check_eq("ovf_frames", frames - fs, DEPTH);
      check_eq("ovf_sb", sb.size(), 0);

      // irq and divisor change mid-frame
      set_div(4);
      wb_wr(2'd3, 32'h3);
      check_eq("irq_idle", irq, 1);
      send(8'h3C, 1);
      pk = last_ack;
      check_eq("irq_busy", irq, 0);
      set_div(8);
      check_eq("irq_mid", irq, 0);
      n = 0;
      while (!irq && n < 200) begin
         @(negedge wb_clk);
         n++;
      end
      check_eq("irq_rise", cyc_n - pk, 41);
      send(8'hA5, 1);
      check_eq("irq_refill", irq, 0);
      wait_done(1);
      check_eq("irq_drained", irq, 1);

      // asynchronous reset mid data bit
      wb_wr(2'd3, 32'h1);
      fs = frames;
      send(8'h00, 1);
      wait_frames(fs + 1);
      repeat (20) @(negedge wb_clk);
      check_eq("tx_pre_rst", tx, 0);
      mon_ignore = 1'b1;
      #2 wb_rst_n = 1'b0;
      #1;
      check_eq("tx_async_rst", tx, 1);
      check_eq("ack_async_rst", wb_ack, 0);
      check_eq("irq_async_rst", irq, 0);
      repeat (2) @(negedge wb_clk);
      wb_rst_n = 1'b1;
      wb_rd(2'd1, r); check_eq("post_rst_status", r, 32'h0000_0001);
      wb_rd(2'd2, r); check_eq("post_rst_div", r, 32);
      wb_rd(2'd3, r); check_eq("post_rst_ctrl", r, 32'h1);
      repeat (100) @(negedge wb_clk);
      check_eq("sb_final", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
